// File: rtl/alu_arbiter_32.sv
// Two-port round-robin front end sharing one alu_32: sequences the enable/strobe
// start protocol, waits out a settle window, then returns result/extra or a timeout error.
module alu_arbiter_32 #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic [1:0]  req0_control,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  input  logic [1:0]  req1_control,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic [31:0] rsp0_extra,
  output logic        rsp0_error,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [31:0] rsp1_extra,
  output logic        rsp1_error,
  output logic        busy,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [1:0]  alu_control,
  output logic        alu_enable,
  output logic        alu_reset,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_extra,
  input  logic        alu_done
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_STROBE, S_SETTLE, S_WAIT, S_RESPOND
  } state_t;

  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] req_op1 [2];
  logic [31:0] req_op2 [2];
  logic [1:0]  req_control [2];

  assign req_valid      = {req1_valid, req0_valid};
  assign rsp_ready      = {rsp1_ready, rsp0_ready};
  assign req_op1[0]     = req0_op1;
  assign req_op1[1]     = req1_op1;
  assign req_op2[0]     = req0_op2;
  assign req_op2[1]     = req1_op2;
  assign req_control[0] = req0_control;
  assign req_control[1] = req1_control;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        cur_q, cur_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [31:0] alu_op1_q, alu_op1_d;
  logic [31:0] alu_op2_q, alu_op2_d;
  logic [1:0]  alu_control_q, alu_control_d;
  logic        alu_enable_q, alu_enable_d;
  logic        alu_reset_q, alu_reset_d;
  logic        busy_q, busy_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_result_q [2];
  logic [31:0] rsp_result_d [2];
  logic [31:0] rsp_extra_q [2];
  logic [31:0] rsp_extra_d [2];
  logic [1:0]  rsp_error_q, rsp_error_d;
  logic [1:0]  req_ready_c;
  logic        grant_idx;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cur_d         = cur_q;
    settle_cnt_d  = settle_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    alu_op1_d     = alu_op1_q;
    alu_op2_d     = alu_op2_q;
    alu_control_d = alu_control_q;
    alu_enable_d  = 1'b0;
    alu_reset_d   = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_extra_d   = rsp_extra_q;
    rsp_error_d   = rsp_error_q;
    req_ready_c   = 2'b00;
    grant_idx     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid != 2'b00) begin
          // With both ports asking, the one that did not win last time goes first.
          grant_idx              = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
          req_ready_c[grant_idx] = 1'b1;
          cur_d                  = grant_idx;
          alu_op1_d              = req_op1[grant_idx];
          alu_op2_d              = req_op2[grant_idx];
          alu_control_d          = req_control[grant_idx];
          alu_enable_d           = 1'b1;
          state_d                = S_ISSUE;
        end
      end
      S_ISSUE: begin
        alu_enable_d = 1'b1;
        alu_reset_d  = 1'b1;
        state_d      = S_STROBE;
      end
      S_STROBE: begin
        settle_cnt_d = '0;
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        // alu_done may still be stale from the previous operation here.
        if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          timeout_cnt_d = '0;
          state_d       = S_WAIT;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (alu_done) begin
          rsp_result_d[cur_q] = alu_result;
          rsp_extra_d[cur_q]  = alu_extra;
          rsp_error_d[cur_q]  = 1'b0;
          rsp_valid_d[cur_q]  = 1'b1;
          state_d             = S_RESPOND;
        end else if (timeout_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_result_d[cur_q] = '0;
          rsp_extra_d[cur_q]  = '0;
          rsp_error_d[cur_q]  = 1'b1;
          rsp_valid_d[cur_q]  = 1'b1;
          state_d             = S_RESPOND;
        end else begin
          timeout_cnt_d = timeout_cnt_q + 1'b1;
        end
      end
      S_RESPOND: begin
        if (rsp_ready[cur_q]) begin
          rsp_valid_d[cur_q] = 1'b0;
          last_grant_d       = cur_q;
          state_d            = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      cur_q         <= 1'b0;
      settle_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      alu_op1_q     <= '0;
      alu_op2_q     <= '0;
      alu_control_q <= '0;
      alu_enable_q  <= 1'b0;
      alu_reset_q   <= 1'b0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 2'b00;
      rsp_result_q  <= '{default: '0};
      rsp_extra_q   <= '{default: '0};
      rsp_error_q   <= 2'b00;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cur_q         <= cur_d;
      settle_cnt_q  <= settle_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      alu_op1_q     <= alu_op1_d;
      alu_op2_q     <= alu_op2_d;
      alu_control_q <= alu_control_d;
      alu_enable_q  <= alu_enable_d;
      alu_reset_q   <= alu_reset_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_extra_q   <= rsp_extra_d;
      rsp_error_q   <= rsp_error_d;
    end
  end

  assign req0_ready  = req_ready_c[0] & ~reset;
  assign req1_ready  = req_ready_c[1] & ~reset;
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_result = rsp_result_q[0];
  assign rsp1_result = rsp_result_q[1];
  assign rsp0_extra  = rsp_extra_q[0];
  assign rsp1_extra  = rsp_extra_q[1];
  assign rsp0_error  = rsp_error_q[0];
  assign rsp1_error  = rsp_error_q[1];
  assign busy        = busy_q;
  assign alu_op1     = alu_op1_q;
  assign alu_op2     = alu_op2_q;
  assign alu_control = alu_control_q;
  assign alu_enable  = alu_enable_q;
  assign alu_reset   = alu_reset_q;

endmodule
